// File: rtl/g3_pkg.sv
// g3_pkg
// Shared definitions for the g3 stimulus/response engine.
//   g3_state_e : sequencer states (IDLE, DRIVE, WAIT, SAMPLE, DONE)
//   VEC_W      : width of an input vector, bit order {a,b,c,d,e,f}
//   RSP_W      : width of a response, bit order {z1,z2}
//   g3_entry_t : one table entry {vec, exp}
package g3_pkg;

    localparam int VEC_W = 6;
    localparam int RSP_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } g3_state_e;

    typedef struct packed {
        logic [VEC_W-1:0] vec;
        logic [RSP_W-1:0] exp;
    } g3_entry_t;

endpackage

// File: rtl/g3_vec_table.sv
// g3_vec_table
// DEPTH-entry register file holding vectors and expected responses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   wr_en      : write strobe; wr_data lands in entry wr_idx on the edge
//   wr_idx     : entry to write
//   wr_data    : entry contents {vec, exp}
//   rd_idx     : entry to read
//   rd_data    : combinational read of entry rd_idx
module g3_vec_table
    import g3_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  g3_entry_t        wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output g3_entry_t        rd_data
);

    g3_entry_t mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/g3_vector_driver.sv
// g3_vector_driver
// Applies a table of input vectors to the g3 gate block one at a time, waits
// SETTLE cycles, samples z1/z2 against the expected response and reports the
// mismatch count and the first failing index.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/wr_idx/
//   wr_vec/wr_exp     : table write port (ignored while busy)
//   num_vec           : entries to run from index 0, clamped to DEPTH
//   start             : single-cycle run request
//   z1, z2            : responses from g3 (same clock domain)
//   a..f              : registered drive to g3
//   busy              : run in progress
//   done, pass        : results valid (level) / done with no mismatches
//   err_count         : saturating mismatch count of the last run
//   fail_valid        : at least one mismatch recorded
//   first_fail        : index of the first mismatching vector
//   dbg_state         : current sequencer state
//
// Handshake: start is a one-cycle request that is accepted only when busy is
// low (state IDLE or DONE); requests while busy are dropped. Acceptance
// clears done, and done then rises as a level that is held until the next
// accepted start, with pass/err_count/fail_valid/first_fail valid alongside.
module g3_vector_driver
    import g3_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [VEC_W-1:0] wr_vec,
    input  logic [RSP_W-1:0] wr_exp,
    input  logic [IDX_W:0]   num_vec,
    input  logic             start,
    input  logic             z1,
    input  logic             z2,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [IDX_W-1:0] first_fail,
    output g3_state_e        dbg_state
);

    localparam int WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [IDX_W:0]   DEPTH_N = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    g3_state_e        state_q, state_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   n_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [VEC_W-1:0] vec_q;
    logic             busy_q, done_q, pass_q, fail_valid_q;
    logic [CNT_W-1:0] err_q;
    logic [IDX_W-1:0] first_fail_q;

    g3_entry_t        rd_entry;
    logic             idle_like;
    logic             start_acc;
    logic [IDX_W:0]   n_sel;
    logic             last_vec;
    logic             wait_over;
    logic             mismatch;
    logic [CNT_W-1:0] err_nxt;

    // Control strobes produced by the output process.
    logic             run_start;
    logic             run_empty;
    logic             drive_en;
    logic             wait_en;
    logic             sample_en;
    logic             finish;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_acc = idle_like && start;
    assign n_sel     = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
    // n_q is at least 1 whenever the run reaches SAMPLE.
    assign last_vec  = ({1'b0, idx_q} == (n_q - 1'b1));
    assign wait_over = (wait_cnt_q == WAIT_W'(SETTLE_M1));
    assign mismatch  = ({z1, z2} != rd_entry.exp);
    assign err_nxt   = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

    // Writes are only honoured outside a run; a write coincident with an
    // accepted start lands on the same edge, ahead of the first DRIVE read.
    g3_vec_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && idle_like),
        .wr_idx  (wr_idx),
        .wr_data ({wr_vec, wr_exp}),
        .rd_idx  (idx_q),
        .rd_data (rd_entry)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = (n_sel == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE:  state_nxt = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
            ST_WAIT:   if (wait_over) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output/strobe logic
    always_comb begin
        run_start = 1'b0;
        run_empty = 1'b0;
        drive_en  = 1'b0;
        wait_en   = 1'b0;
        sample_en = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                run_start = start_acc;
                run_empty = start_acc && (n_sel == '0);
            end
            ST_DRIVE:  drive_en = 1'b1;
            ST_WAIT:   wait_en  = 1'b1;
            ST_SAMPLE: begin
                sample_en = 1'b1;
                finish    = last_vec;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            n_q          <= '0;
            wait_cnt_q   <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            if (run_start) begin
                idx_q        <= '0;
                n_q          <= n_sel;
                err_q        <= '0;
                fail_valid_q <= 1'b0;
                first_fail_q <= '0;
                if (run_empty) begin
                    done_q <= 1'b1;
                    pass_q <= 1'b1;
                end else begin
                    done_q <= 1'b0;
                    pass_q <= 1'b0;
                    busy_q <= 1'b1;
                end
            end

            if (drive_en) begin
                vec_q      <= rd_entry.vec;
                wait_cnt_q <= '0;
            end

            if (wait_en) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end

            if (sample_en) begin
                err_q <= err_nxt;
                if (mismatch && !fail_valid_q) begin
                    fail_valid_q <= 1'b1;
                    first_fail_q <= idx_q;
                end
                if (finish) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_nxt == '0);
                    vec_q  <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign {a, b, c, d, e, f} = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_g3_vector_driver.sv
module tb_g3_vector_driver;
    import g3_pkg::*;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 2;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [5:0]       wr_vec;
    logic [1:0]       wr_exp;
    logic [IDX_W:0]   num_vec;
    logic             start;
    logic             z1, z2;
    logic             a, b, c, d, e, f;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_count;
    logic             fail_valid;
    logic [IDX_W-1:0] first_fail;
    g3_state_e        dbg_state;

    int n_vec;
    int n_err;

    logic [5:0] exp_q[$];

    g3_vector_driver #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .SETTLE (SETTLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_vec     (wr_vec),
        .wr_exp     (wr_exp),
        .num_vec    (num_vec),
        .start      (start),
        .z1         (z1),
        .z2         (z2),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .first_fail (first_fail),
        .dbg_state  (dbg_state)
    );

    // Behavioural stand-in for g3.
    assign z1 = a & b & c;
    assign z2 = d | e | f;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model_rsp(input logic [5:0] v);
        return {v[5] & v[4] & v[3], v[2] | v[1] | v[0]};
    endfunction

    // Driver tasks
    task automatic write_entry(input int idx, input logic [5:0] vec, input logic [1:0] ex);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_idx = idx[IDX_W-1:0];
        wr_vec = vec;
        wr_exp = ex;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    // Pulses start; returns #1 after the accepting edge.
    task automatic pulse_start(input int n);
        @(negedge clk);
        num_vec = n[IDX_W:0];
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: done=%b required 1 within 200 cycles", tag, done);
        end
    endtask

    task automatic check_result(input string tag, input logic ps, input logic [CNT_W-1:0] ec,
                                input logic fv, input logic [IDX_W-1:0] ff);
        n_vec++;
        if ({done, busy, pass, err_count, fail_valid, first_fail} !== {1'b1, 1'b0, ps, ec, fv, ff}) begin
            n_err++;
            $display("FAIL %s_result: done=%b busy=%b pass=%b err=%0d fv=%b ff=%0d required done=1 busy=0 pass=%b err=%0d fv=%b ff=%0d",
                     tag, done, busy, pass, err_count, fail_valid, first_fail, ps, ec, fv, ff);
        end
    endtask

    task automatic load_base_table();
        write_entry(0, 6'b000000, 2'b00);
        write_entry(1, 6'b111111, 2'b11);
        write_entry(2, 6'b010101, 2'b01);
        write_entry(3, 6'b101010, 2'b01);
    endtask

    // Steps through a 4-vector run cycle by cycle; optional disturbance
    // (start + wr_en) is injected mid-run.
    task automatic run_base_stepped(input string tag, input logic disturb);
        exp_q.delete();
        exp_q.push_back(6'b000000);
        exp_q.push_back(6'b111111);
        exp_q.push_back(6'b010101);
        exp_q.push_back(6'b101010);
        @(negedge clk);
        num_vec = 4;
        start   = 1'b1;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (disturb && cyc == 4) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = 3'd3;
                wr_vec  = 6'b111000;
                wr_exp  = 2'b00;
                num_vec = 1;
            end
            if (disturb && cyc == 5) begin
                wr_en   = 1'b0;
            end
            if (cyc % 3 == 0 && cyc <= 12) begin
                logic [5:0] ev;
                ev = exp_q.pop_front();
                n_vec++;
                if ({a, b, c, d, e, f} !== ev) begin
                    n_err++;
                    $display("FAIL %s_drive_c%0d: abcdef=%b required %b", tag, cyc, {a, b, c, d, e, f}, ev);
                end
            end
            if (cyc <= 12) begin
                n_vec++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_busy_c%0d: busy=%b done=%b required busy=1 done=0", tag, cyc, busy, done);
                end
            end
        end
        n_vec++;
        if (done !== 1'b1 || {a, b, c, d, e, f} !== 6'b0) begin
            n_err++;
            $display("FAIL %s_done_c13: done=%b abcdef=%b required done=1 abcdef=000000", tag, done, {a, b, c, d, e, f});
        end
        check_result(tag, 1'b1, 2'd0, 1'b0, 3'd0);
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({a, b, c, d, e, f, busy, done, pass, err_count, fail_valid, first_fail} !== '0 ||
            dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_outputs: abcdef=%b busy=%b done=%b pass=%b err=%0d fv=%b ff=%0d state=%0d required all 0, IDLE",
                     {a, b, c, d, e, f}, busy, done, pass, err_count, fail_valid, first_fail, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_pass();
        load_base_table();
        run_base_stepped("basic", 1'b0);
    endtask

    task automatic test_single_mismatch();
        write_entry(2, 6'b010101, 2'b10);
        pulse_start(4);
        wait_done("mismatch");
        check_result("mismatch", 1'b0, 2'd1, 1'b1, 3'd2);
        write_entry(2, 6'b010101, 2'b01);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < DEPTH; i++) begin
            logic [5:0] v;
            logic [2:0] k;
            k = i[2:0];
            v = {k, ~k};
            write_entry(i, v, ~model_rsp(v));
        end
        // 15 exceeds DEPTH and must clamp to 8 entries.
        pulse_start(15);
        wait_done("saturate");
        check_result("saturate", 1'b0, 2'd3, 1'b1, 3'd0);
    endtask

    task automatic test_empty_run();
        pulse_start(0);
        n_vec++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || err_count !== 2'd0 || fail_valid !== 1'b0) begin
            n_err++;
            $display("FAIL empty_done: done=%b pass=%b busy=%b err=%0d fv=%b required done=1 pass=1 busy=0 err=0 fv=0",
                     done, pass, busy, err_count, fail_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (busy !== 1'b0 || {a, b, c, d, e, f} !== 6'b0 || done !== 1'b1) begin
                n_err++;
                $display("FAIL empty_idle_%0d: busy=%b abcdef=%b done=%b required busy=0 abcdef=000000 done=1",
                         i, busy, {a, b, c, d, e, f}, done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        load_base_table();
        pulse_start(4);
        // Accepting edge was E0; after E4 the run sits in WAIT of vector 1.
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (dbg_state !== ST_WAIT || {a, b, c, d, e, f} !== 6'b111111) begin
            n_err++;
            $display("FAIL midrun_pre: state=%0d abcdef=%b required WAIT 111111", dbg_state, {a, b, c, d, e, f});
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a, b, c, d, e, f, busy, done, pass, err_count, fail_valid, first_fail} !== '0 ||
            dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL midrun_reset: abcdef=%b busy=%b done=%b pass=%b err=%0d state=%0d required all 0, IDLE",
                     {a, b, c, d, e, f}, busy, done, pass, err_count, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(1);
        wait_done("midrun_one");
        check_result("midrun_one", 1'b1, 2'd0, 1'b0, 3'd0);
        // Entry 1 was 111111/11 before reset; a full run only passes if every
        // entry reads back as 000000/00.
        pulse_start(8);
        wait_done("midrun_all");
        check_result("midrun_all", 1'b1, 2'd0, 1'b0, 3'd0);
    endtask

    task automatic test_back_to_back();
        load_base_table();
        run_base_stepped("busy_ignore", 1'b1);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        // Entry 3 must still hold 101010/01.
        pulse_start(4);
        wait_done("table_kept");
        check_result("table_kept", 1'b1, 2'd0, 1'b0, 3'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_vec  = '0;
        wr_exp  = '0;
        num_vec = '0;
        start   = 1'b0;

        test_reset();
        test_basic_pass();
        test_single_mismatch();
        test_saturate();
        test_empty_run();
        test_reset_mid_run();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/g3_vector_driver.md
Name: g3_vector_driver

Overview:
- Sequential stimulus/response engine that drives the 6-input/2-output g3 gate block: it is the driving-and-checking end of the a..f -> z1/z2 interface.
- Holds a small loadable table of input vectors with expected outputs, applies them one at a time, waits a settle time, samples z1/z2 and compares.
- Reports a mismatch count and the first failing index.
- Sits beside g3 in on-chip self-test builds and replaces the hand-driven vectors in simulation.

Parameters:
- DEPTH, 8, number of vector table entries (power of 2, ≥2).
- IDX_W, 3, log2(DEPTH).
- SETTLE, 1, idle cycles between driving a vector and sampling z1/z2 (≥0).
- CNT_W, 4, width of the mismatch counter.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  table write strobe.
- wr_idx  in  IDX_W  table entry to write.
- wr_vec  in  6  input vector, bit order {a,b,c,d,e,f}.
- wr_exp  in  2  expected response, bit order {z1,z2}.
- num_vec  in  IDX_W+1  number of entries to run, from index 0 upward.
- start  in  1  single-cycle run request.
- z1, z2  in  1 each  responses from g3.
- a, b, c, d, e, f  out  1 each  registered drive to g3.
- busy  out  1  run in progress.
- done  out  1  results valid; level, held until the next accepted start.
- pass  out  1  done with err_count==0.
- err_count  out  CNT_W  mismatches in the last run, saturating.
- fail_valid  out  1  at least one mismatch recorded.
- first_fail  out  IDX_W  index of the first mismatching vector.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Table entries clear to vec=000000, exp=00.
  - Reset mid-run aborts immediately; no partial result is retained.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE/DONE:
  - a..f = 0.
  - wr_en writes table[wr_idx] <= {wr_vec, wr_exp} on the edge.
  - On start:
    - Clear err_count, fail_valid and first_fail; done <= 0; latch n = min(num_vec, DEPTH).
    - If n==0: go to DONE next cycle with pass=1.
    - Otherwise set idx=0 and go to DRIVE; busy=1 from the next cycle.
  - If start and wr_en occur together, the write lands first and the run uses the new entry.
- DRIVE (1 cycle): a..f <= table[idx].vec. Next state is WAIT if SETTLE>0, else SAMPLE.
- WAIT: counts SETTLE cycles, then goes to SAMPLE.
- SAMPLE (1 cycle): compare {z1,z2} with table[idx].exp.
  - On mismatch: err_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch of a run: fail_valid <= 1, first_fail <= idx.
  - If idx==n-1, go to DONE; otherwise idx++ and go to DRIVE.
  - a..f hold their value through SAMPLE.
- Entering DONE: busy <= 0, done <= 1, pass <= (err_count==0 including the final compare), a..f <= 0.
- Timing:
  - Each vector takes SETTLE+2 cycles.
  - With SETTLE=1 and n=4, a run takes 12 cycles from the cycle after start, plus 1 cycle to DONE.
- While busy: start and wr_en are ignored. num_vec is sampled only at start.
- z1/z2 are sampled directly with no synchronizer; g3 is same-clock combinational logic.

Decomposition:
- Shared package g3_pkg holds:
  - state enum (IDLE, DRIVE, WAIT, SAMPLE, DONE);
  - VEC_W=6 and RSP_W=2;
  - the table entry struct {vec[5:0], exp[1:0]}.
- One natural sub-module: g3_vec_table, a DEPTH-entry register file with one write port, one async read port and async clear.
- The FSM, counters and compare logic stay in the top module.

Test Plan:
The bench ties z1=a&b&c and z2=d|e|f as the behavioural stand-in for g3.
- Load 000000/00, 111111/11, 010101/01, 101010/01; num_vec=4; pulse start -> a..f show each vector in turn, done=1 after 13 cycles, pass=1, err_count=0, fail_valid=0.
- Same table with entry 2 expected changed to 10 -> err_count=1, fail_valid=1, first_fail=2, pass=0.
- All 8 entries with wrong expectations, CNT_W=2 -> err_count saturates at 3, first_fail=0.
- num_vec=0 then start -> done=1 one cycle later, pass=1, busy never asserted, a..f remain 0.
- Pulse rst_n low during the WAIT of vector 1 -> all outputs 0 immediately; table reads back zeros; a new start with num_vec=1 expects 00 and passes.
- start and wr_en pulsed while busy -> no effect on the run or the table; results match the first scenario.
